// File: rtl/filter_scratch_ring_pkg.sv
// filter_scratch_pkg: shared types and default sizing for the filter scratch ring.
//   DEF_SCRATCH_WIDTH        default bits per filter word
//   DEF_SCRATCH_ADDRESS_SIZE default address bits
//   DEPTH                    entries at the default address size
//   ptr_t / cnt_t            pointer and live-count types at the default size
package filter_scratch_pkg;
  localparam int DEF_SCRATCH_WIDTH        = 8;
  localparam int DEF_SCRATCH_ADDRESS_SIZE = 4;
  localparam int DEPTH                    = 2 ** DEF_SCRATCH_ADDRESS_SIZE;

  typedef logic [DEF_SCRATCH_ADDRESS_SIZE-1:0] ptr_t;
  typedef logic [DEF_SCRATCH_ADDRESS_SIZE:0]   cnt_t;
endpackage

// File: rtl/filter_scratch_ring_mem.sv
// scratch_mem_1r1w: DEPTH x SCRATCH_WIDTH storage with one synchronous write
// port and one registered read port. The array itself is never reset; only
// the read register is cleared by rst.
//   clk, rst       clock and synchronous active-high reset (read register only)
//   we/waddr/wdata write port, written on the rising edge
//   re/raddr       read request; rdata loads mem[raddr] on the next edge
//   rdata          registered read data, holds when re is low
// A read and write to the same address in one cycle returns the old word.
module scratch_mem_1r1w #(
  parameter int SCRATCH_WIDTH        = 8,
  parameter int SCRATCH_ADDRESS_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [SCRATCH_ADDRESS_SIZE-1:0] waddr,
  input  logic [SCRATCH_WIDTH-1:0]        wdata,
  input  logic                            re,
  input  logic [SCRATCH_ADDRESS_SIZE-1:0] raddr,
  output logic [SCRATCH_WIDTH-1:0]        rdata
);
  logic [SCRATCH_WIDTH-1:0] mem [2**SCRATCH_ADDRESS_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/filter_scratch_ring.sv
// filter_scratch_ring: circular filter scratchpad. Words are appended at
// wr_ptr, read by offset from base_ptr (oldest live entry) and freed in bulk
// by release, so the PE's filter window slides without address management.
//
// Write handshake: a word transfers on a rising edge where chip_en, wr_valid
// and wr_ready are all high; wr_ready = chip_en & ~full depends only on the
// registered count, never on wr_valid or a same-cycle release.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   chip_en              block enable; low freezes all state
//   wr_valid/wr_ready/din  write handshake and data
//   rd_en/rd_offset      read request at offset from base
//   dout/dout_valid      registered read data and its one-cycle pulse
//   release_en/release_cnt  free entries from base (clamped to count)
//   occupancy/full/empty live-entry status
//   last_write           physical address of the next write slot
// Optional (macro FILTER_SCRATCH_ERR_EN): err_clr input and sticky
// err_overflow, err_rd_range, err_release outputs.
module filter_scratch_ring
  import filter_scratch_pkg::*;
#(
  parameter int SCRATCH_WIDTH        = DEF_SCRATCH_WIDTH,
  parameter int SCRATCH_ADDRESS_SIZE = DEF_SCRATCH_ADDRESS_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            chip_en,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [SCRATCH_WIDTH-1:0]        din,
  input  logic                            rd_en,
  input  logic [SCRATCH_ADDRESS_SIZE-1:0] rd_offset,
  output logic [SCRATCH_WIDTH-1:0]        dout,
  output logic                            dout_valid,
  input  logic                            release_en,
  input  logic [SCRATCH_ADDRESS_SIZE:0]   release_cnt,
  output logic [SCRATCH_ADDRESS_SIZE:0]   occupancy,
  output logic                            full,
  output logic                            empty,
  output logic [SCRATCH_ADDRESS_SIZE-1:0] last_write
`ifdef FILTER_SCRATCH_ERR_EN
  ,
  input  logic                            err_clr,
  output logic                            err_overflow,
  output logic                            err_rd_range,
  output logic                            err_release
`endif
);
  localparam int AW         = SCRATCH_ADDRESS_SIZE;
  localparam int CW         = SCRATCH_ADDRESS_SIZE + 1;
  localparam int RING_DEPTH = 2 ** SCRATCH_ADDRESS_SIZE;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] base_ptr;
  logic [CW-1:0] count;

  logic          wr_fire;
  logic          rd_ok;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rel_amt;

  assign full       = (count == CW'(RING_DEPTH));
  assign empty      = (count == '0);
  assign wr_ready   = chip_en & ~full;
  assign occupancy  = count;
  assign last_write = wr_ptr;

  assign wr_fire = chip_en & wr_valid & wr_ready;
  // Only live entries are readable; a slot being written this cycle is
  // outside the live range, so reads never race the write port.
  assign rd_ok   = chip_en & rd_en & ({1'b0, rd_offset} < count);
  assign rd_addr = base_ptr + rd_offset;

  always_comb begin
    rel_amt = '0;
    if (chip_en && release_en)
      rel_amt = (release_cnt > count) ? count : release_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      base_ptr   <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      // Releasing a full ring (rel_amt == DEPTH) leaves base unchanged mod DEPTH.
      base_ptr   <= base_ptr + rel_amt[AW-1:0];
      count      <= count + CW'(wr_fire) - rel_amt;
      dout_valid <= rd_ok;
    end
  end

  scratch_mem_1r1w #(
    .SCRATCH_WIDTH       (SCRATCH_WIDTH),
    .SCRATCH_ADDRESS_SIZE(SCRATCH_ADDRESS_SIZE)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_fire),
    .waddr(wr_ptr),
    .wdata(din),
    .re   (rd_ok),
    .raddr(rd_addr),
    .rdata(dout)
  );

`ifdef FILTER_SCRATCH_ERR_EN
  logic set_overflow;
  logic set_rd_range;
  logic set_release;

  assign set_overflow = chip_en & wr_valid & full;
  assign set_rd_range = chip_en & rd_en & ({1'b0, rd_offset} >= count);
  assign set_release  = chip_en & release_en & (release_cnt > count);

  // Sticky flags: a new event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
      err_rd_range <= 1'b0;
      err_release  <= 1'b0;
    end else begin
      if (set_overflow)  err_overflow <= 1'b1;
      else if (err_clr)  err_overflow <= 1'b0;
      if (set_rd_range)  err_rd_range <= 1'b1;
      else if (err_clr)  err_rd_range <= 1'b0;
      if (set_release)   err_release  <= 1'b1;
      else if (err_clr)  err_release  <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_filter_scratch_ring.sv
// Testbench for filter_scratch_ring. The reference model keeps the live
// window as a queue of words (oldest first): writes append, releases pop from
// the front, reads index the queue by offset. last_write is the total number
// of accepted writes modulo DEPTH.
module tb_filter_scratch_ring;
  import filter_scratch_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       chip_en = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] din = '0;
  logic       rd_en = 1'b0;
  ptr_t       rd_offset = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       release_en = 1'b0;
  cnt_t       release_cnt = '0;
  cnt_t       occupancy;
  logic       full;
  logic       empty;
  ptr_t       last_write;
`ifdef FILTER_SCRATCH_ERR_EN
  logic       err_clr = 1'b0;
  logic       err_overflow;
  logic       err_rd_range;
  logic       err_release;
`endif

  filter_scratch_ring dut (
    .clk        (clk),
    .rst        (rst),
    .chip_en    (chip_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .din        (din),
    .rd_en      (rd_en),
    .rd_offset  (rd_offset),
    .dout       (dout),
    .dout_valid (dout_valid),
    .release_en (release_en),
    .release_cnt(release_cnt),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .last_write (last_write)
`ifdef FILTER_SCRATCH_ERR_EN
    ,
    .err_clr     (err_clr),
    .err_overflow(err_overflow),
    .err_rd_range(err_rd_range),
    .err_release (err_release)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_dout;
  bit         exp_valid;
  int         wr_total;
  int         n_cmp;
  int         n_fail;

  // Drive one cycle of stimulus, advance the model with the same inputs,
  // then return #1 after the edge so outputs can be sampled.
  task automatic drive(input bit ce, input bit wv, input logic [7:0] d,
                       input bit re, input int off, input bit rel, input int rc);
    int  n_rel;
    bit  wfire;
    chip_en     = ce;
    wr_valid    = wv;
    din         = d;
    rd_en       = re;
    rd_offset   = ptr_t'(off);
    release_en  = rel;
    release_cnt = cnt_t'(rc);
    exp_valid = 1'b0;
    if (ce && re && off < exp_q.size()) begin
      exp_dout  = exp_q[off];
      exp_valid = 1'b1;
    end
    wfire = ce && wv && (exp_q.size() < DEPTH);
    n_rel = (ce && rel) ? ((rc < exp_q.size()) ? rc : exp_q.size()) : 0;
    repeat (n_rel) void'(exp_q.pop_front());
    if (wfire) begin
      exp_q.push_back(d);
      wr_total++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    wr_total  = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    chip_en = 1'b1;
    do_reset();
    n_cmp++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b want=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", full); end
    n_cmp++; if (last_write !== 4'd0) begin n_fail++; $display("FAIL reset_last_write got=%0d want=0", last_write); end
    n_cmp++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout got=%h/%b want=00/0", dout, dout_valid); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d got=%b want=1", i, wr_ready); end
      drive(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 0, 1'b0, 0);
    end
    wr_valid = 1'b0;
    n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full got=%b want=0", wr_ready); end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b want=1", full); end
    n_cmp++; if (occupancy !== 5'd16) begin n_fail++; $display("FAIL fill_occ got=%0d want=16", occupancy); end
    n_cmp++; if (last_write !== 4'd0) begin n_fail++; $display("FAIL fill_last_write got=%0d want=0", last_write); end
  endtask

  task automatic test_read_full();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 3, 1'b0, 0);
    n_cmp++; if (dout !== 8'h13 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL read_off3 got=%h/%b want=13/1", dout, dout_valid); end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 15, 1'b0, 0);
    n_cmp++; if (dout !== 8'h1F || dout_valid !== 1'b1) begin n_fail++; $display("FAIL read_off15 got=%h/%b want=1f/1", dout, dout_valid); end
    idle();
    n_cmp++; if (dout !== 8'h1F || dout_valid !== 1'b0) begin n_fail++; $display("FAIL read_hold got=%h/%b want=1f/0", dout, dout_valid); end
  endtask

  task automatic test_release_wrap();
    // Release 4 while a write is offered on a full ring: write must be refused.
    drive(1'b1, 1'b1, 8'h55, 1'b0, 0, 1'b1, 4);
    n_cmp++; if (occupancy !== 5'd12) begin n_fail++; $display("FAIL rel_occ got=%0d want=12", occupancy); end
    n_cmp++; if (last_write !== 4'd0) begin n_fail++; $display("FAIL rel_no_write got=%0d want=0", last_write); end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 0);
    n_cmp++; if (dout !== 8'h14) begin n_fail++; $display("FAIL rel_base got=%h want=14", dout); end
    drive(1'b1, 1'b1, 8'hAA, 1'b0, 0, 1'b0, 0);
    n_cmp++; if (last_write !== 4'd1 || occupancy !== 5'd13) begin n_fail++; $display("FAIL wrap_write got=%0d/%0d want=1/13", last_write, occupancy); end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 12, 1'b0, 0);
    n_cmp++; if (dout !== 8'hAA || dout_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_read got=%h/%b want=aa/1", dout, dout_valid); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    drive(1'b1, 1'b1, 8'h77, 1'b0, 0, 1'b0, 0);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 0);
    n_cmp++; if (dout !== 8'h77 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL oor_setup got=%h/%b want=77/1", dout, dout_valid); end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL oor_empty got=%b want=1", empty); end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 0);
    n_cmp++; if (dout !== 8'h77 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL oor_read got=%h/%b want=77/0", dout, dout_valid); end
`ifdef FILTER_SCRATCH_ERR_EN
    n_cmp++; if (err_rd_range !== 1'b1) begin n_fail++; $display("FAIL err_rd_range_set got=%b want=1", err_rd_range); end
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    n_cmp++; if (err_rd_range !== 1'b0) begin n_fail++; $display("FAIL err_rd_range_clr got=%b want=0", err_rd_range); end
`endif
  endtask

  task automatic test_over_release();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0, 0, 1'b0, 0);
    n_cmp++; if (occupancy !== 5'd5) begin n_fail++; $display("FAIL orel_pre got=%0d want=5", occupancy); end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 20);
    n_cmp++; if (occupancy !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL orel_occ got=%0d/%b want=0/1", occupancy, empty); end
`ifdef FILTER_SCRATCH_ERR_EN
    n_cmp++; if (err_release !== 1'b1) begin n_fail++; $display("FAIL err_release got=%b want=1", err_release); end
`endif
    // Base must now sit on the next write slot: a new word is offset 0.
    drive(1'b1, 1'b1, 8'h3C, 1'b0, 0, 1'b0, 0);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 0);
    n_cmp++; if (dout !== 8'h3C || dout_valid !== 1'b1) begin n_fail++; $display("FAIL orel_base got=%h/%b want=3c/1", dout, dout_valid); end
    n_cmp++; if (last_write !== ptr_t'(wr_total % DEPTH)) begin n_fail++; $display("FAIL orel_last_write got=%0d want=%0d", last_write, wr_total % DEPTH); end
  endtask

  task automatic test_chip_en();
    int occ_before;
    drive(1'b1, 1'b1, 8'h61, 1'b0, 0, 1'b0, 0);
    drive(1'b1, 1'b1, 8'h62, 1'b1, 0, 1'b0, 0);
    occ_before = exp_q.size();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h99, 1'b1, 0, 1'b1, 3);
      n_cmp++; if (occupancy !== 5'(occ_before) || last_write !== ptr_t'(wr_total % DEPTH)) begin
        n_fail++; $display("FAIL dis_hold_%0d got=%0d/%0d want=%0d/%0d", i, occupancy, last_write, occ_before, wr_total % DEPTH); end
      n_cmp++; if (wr_ready !== 1'b0 || dout_valid !== 1'b0 || dout !== exp_dout) begin
        n_fail++; $display("FAIL dis_out_%0d got=%b/%b/%h want=0/0/%h", i, wr_ready, dout_valid, dout, exp_dout); end
    end
    // Reset in the middle of active traffic.
    chip_en = 1'b1; wr_valid = 1'b1; rd_en = 1'b1; rd_offset = '0; release_en = 1'b1; release_cnt = 5'd1;
    do_reset();
    chip_en = 1'b1; wr_valid = 1'b0; rd_en = 1'b0; release_en = 1'b0;
    n_cmp++; if (occupancy !== 5'd0 || last_write !== 4'd0) begin n_fail++; $display("FAIL mid_rst_ptr got=%0d/%0d want=0/0", occupancy, last_write); end
    n_cmp++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dout got=%h/%b want=00/0", dout, dout_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, 8'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 15),
            $urandom_range(0, 9) < 2, $urandom_range(0, 20));
      n_cmp++; if (occupancy !== 5'(exp_q.size()) || full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
        n_fail++; $display("FAIL rand_occ_%0d got=%0d/%b/%b want=%0d", i, occupancy, full, empty, exp_q.size()); end
      n_cmp++; if (last_write !== ptr_t'(wr_total % DEPTH)) begin
        n_fail++; $display("FAIL rand_last_write_%0d got=%0d want=%0d", i, last_write, wr_total % DEPTH); end
      n_cmp++; if (dout_valid !== exp_valid || dout !== exp_dout) begin
        n_fail++; $display("FAIL rand_dout_%0d got=%h/%b want=%h/%b", i, dout, dout_valid, exp_dout, exp_valid); end
      n_cmp++; if (wr_ready !== (chip_en && exp_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_wr_ready_%0d got=%b", i, wr_ready); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_dout = '0;
    exp_valid = 1'b0;
    wr_total = 0;
    test_reset();
    test_fill();
    test_read_full();
    test_release_wrap();
    test_out_of_range();
    test_over_release();
    test_chip_en();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
